fft_cmult_pipe: RTL

Pipelined signed complex multiplier for FFT/IFFT butterflies. Computes (iRE + j·iIM)·(W_RE ± j·W_IM) with fixed 3-cycle latency and a valid flag that travels with the data. Adds a per-sample conjugate mode for the inverse transform, selectable rounding, output saturation with a sticky overflow flag, and a global clock-enable stall. Sits between the twiddle ROM and the butterfly adder stage.

---
 rtl/fft_cmult_pipe.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fft_cmult_pipe.sv
// fft_cmult_pipe: 3-stage signed complex multiplier for FFT/IFFT butterflies.
// Optional conj twiddle, rounding, saturation, sticky overflow, clock-enable stall.
module fft_cmult_pipe #(
    parameter int D_BIT = 17,
    parameter int W_BIT = 12,
    parameter int ROUND = 1
) (
    input  logic                    iCLK,
    input  logic                    iRESET,
    input  logic                    iCE,
    input  logic                    iVALID,
    input  logic                    iCONJ,
    input  logic signed [D_BIT-1:0] iRE,
    input  logic signed [D_BIT-1:0] iIM,
    input  logic signed [W_BIT-1:0] iW_RE,
    input  logic signed [W_BIT-1:0] iW_IM,
    input  logic                    iCLR_OVF,
    output logic                    oVALID,
    output logic signed [D_BIT-1:0] oRE,
    output logic signed [D_BIT-1:0] oIM,
    output logic                    oOVF
);

    localparam int P_BIT = D_BIT + W_BIT + 1;
    localparam int S_BIT = P_BIT + 1;
    localparam int SH    = W_BIT - 2;

    localparam logic signed [S_BIT-1:0] MAXV =
        {{(S_BIT-D_BIT+1){1'b0}}, {(D_BIT-1){1'b1}}};
    localparam logic signed [S_BIT-1:0] MINV =
        {{(S_BIT-D_BIT+1){1'b1}}, {(D_BIT-1){1'b0}}};

    // stage 1 registers
    logic                    v1_q;
    logic signed [D_BIT-1:0] re1_q, im1_q;
    logic signed [W_BIT-1:0] wre1_q;
    logic signed [W_BIT:0]   wim1_q, wim1_d;

    // stage 2 registers
    logic                    v2_q;
    logic signed [P_BIT-1:0] rr_q, ii_q, ri_q, ir_q;
    logic signed [P_BIT-1:0] rr_d, ii_d, ri_d, ir_d;

    // stage 3 registers
    logic                    v3_q;
    logic signed [D_BIT-1:0] re3_q, im3_q, re3_d, im3_d;
    logic                    ovf_q, ovf_d;

    logic signed [S_BIT-1:0] rnd_c;
    logic signed [S_BIT-1:0] pr_s, pi_s, pr_sh, pi_sh;
    logic                    re_hi, re_lo, im_hi, im_lo;
    logic                    sat_c;

    // stage 1: widen imaginary twiddle by one bit so negating the minimum is exact
    always_comb begin
        wim1_d = (W_BIT+1)'(iW_IM);
        if (iCONJ) begin
            wim1_d = -(W_BIT+1)'(iW_IM);
        end
    end

    // stage 2: the four partial products at full width
    always_comb begin
        rr_d = P_BIT'(re1_q) * P_BIT'(wre1_q);
        ii_d = P_BIT'(im1_q) * P_BIT'(wim1_q);
        ri_d = P_BIT'(re1_q) * P_BIT'(wim1_q);
        ir_d = P_BIT'(im1_q) * P_BIT'(wre1_q);
    end

    // stage 3: sum, round, scale back to data range, saturate, flag overflow
    always_comb begin
        rnd_c = '0;
        if (ROUND != 0) begin
            rnd_c[W_BIT-3] = 1'b1;
        end
        pr_s  = S_BIT'(rr_q) - S_BIT'(ii_q) + rnd_c;
        pi_s  = S_BIT'(ri_q) + S_BIT'(ir_q) + rnd_c;
        pr_sh = pr_s >>> SH;
        pi_sh = pi_s >>> SH;
        re_hi = pr_sh > MAXV;
        re_lo = pr_sh < MINV;
        im_hi = pi_sh > MAXV;
        im_lo = pi_sh < MINV;
        re3_d = pr_sh[D_BIT-1:0];
        if (re_hi) re3_d = MAXV[D_BIT-1:0];
        if (re_lo) re3_d = MINV[D_BIT-1:0];
        im3_d = pi_sh[D_BIT-1:0];
        if (im_hi) im3_d = MAXV[D_BIT-1:0];
        if (im_lo) im3_d = MINV[D_BIT-1:0];
        sat_c = v2_q & (re_hi | re_lo | im_hi | im_lo);
        ovf_d = sat_c | (ovf_q & ~iCLR_OVF);
    end

    // pipeline registers: async clear, everything holds while iCE is low
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            v1_q   <= 1'b0;
            re1_q  <= '0;
            im1_q  <= '0;
            wre1_q <= '0;
            wim1_q <= '0;
            v2_q   <= 1'b0;
            rr_q   <= '0;
            ii_q   <= '0;
            ri_q   <= '0;
            ir_q   <= '0;
            v3_q   <= 1'b0;
            re3_q  <= '0;
            im3_q  <= '0;
            ovf_q  <= 1'b0;
        end else if (iCE) begin
            v1_q   <= iVALID;
            re1_q  <= iRE;
            im1_q  <= iIM;
            wre1_q <= iW_RE;
            wim1_q <= wim1_d;
            v2_q   <= v1_q;
            rr_q   <= rr_d;
            ii_q   <= ii_d;
            ri_q   <= ri_d;
            ir_q   <= ir_d;
            v3_q   <= v2_q;
            re3_q  <= re3_d;
            im3_q  <= im3_d;
            ovf_q  <= ovf_d;
        end
    end

    assign oVALID = v3_q;
    assign oRE    = re3_q;
    assign oIM    = im3_q;
    assign oOVF   = ovf_q;

endmodule
